// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin sharing of the RAM write port and read port A
// between two single-beat req/ack masters (M0 = CPU datapath, M1 = loader/debug).
module ram_port_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                owner_q, owner_d;            // 0 = M0, 1 = M1
    logic                last_grant_q, last_grant_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;
    logic                winner;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;

        // A lone requester wins outright; a tie goes to whoever was not served last.
        winner = ~last_grant_q;
        if (m0_req && !m1_req) begin
            winner = 1'b0;
        end else if (m1_req && !m0_req) begin
            winner = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    owner_d      = winner;
                    last_grant_d = winner;
                    we_d         = winner ? m1_we    : m0_we;
                    addr_d       = winner ? m1_addr  : m0_addr;
                    wdata_d      = winner ? m1_wdata : m0_wdata;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                // Captured on the same edge that commits a write, so a write returns old contents.
                if (owner_q) begin
                    m1_rdata_d = ram_rdata;
                end else begin
                    m0_rdata_d = ram_rdata;
                end
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state uses non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: datapath regs are reset too, because every output must read 0 during reset.
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
        end
    end

    // ram_we decodes straight from state, so an async reset mid-ACCESS kills the write at once.
    assign ram_we    = (state_q == ACCESS) && we_q;
    assign ram_waddr = addr_q;
    assign ram_raddr = addr_q;
    assign ram_wdata = wdata_q;
    assign m0_ack    = (state_q == RESP) && !owner_q;
    assign m1_ack    = (state_q == RESP) &&  owner_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed and random traffic from two masters, checked every
// cycle against a transaction-level model of the arbiter and of the RAM contents.
module tb_ram_port_arbiter;

    typedef struct packed {
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [7:0]  m0_addr = '0;
    logic [15:0] m0_wdata = '0;
    logic        m0_ack;
    logic [15:0] m0_rdata;
    logic        m1_req = 1'b0, m1_we = 1'b0;
    logic [7:0]  m1_addr = '0;
    logic [15:0] m1_wdata = '0;
    logic        m1_ack;
    logic [15:0] m1_rdata;
    logic        ram_we;
    logic [7:0]  ram_waddr, ram_raddr;
    logic [15:0] ram_wdata, ram_rdata;
    logic        busy;

    // RAM seen by the DUT, and the contents the model says it should hold.
    logic [15:0] ram [256];
    logic [15:0] mem_model [256];

    int total = 0;
    int bad   = 0;

    ram_port_arbiter #(.ADDR_W(8), .DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .ram_raddr(ram_raddr), .ram_rdata(ram_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    assign ram_rdata = ram[ram_raddr];

    // Masters: a queue of pending transactions each, one presented at a time.
    txn_t q0[$];
    txn_t q1[$];
    txn_t cur[2];
    bit   act[2];
    int   req_cyc[2];
    int   lat[2];
    int   ack_cnt[2];
    int   ack_log[$];
    int   we_cnt = 0;
    int   cyc = 0;

    // Model: phase of the transaction in flight (0 none, 1 RAM cycle, 2 ack cycle).
    int          tx_phase = 0;
    bit          mdl_last = 1'b1;
    bit          mdl_owner = 1'b0;
    bit          mdl_we = 1'b0;
    logic [7:0]  mdl_addr = '0;
    logic [15:0] mdl_wdata = '0;
    logic [15:0] mdl_rdata [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic txn_t mk(input bit we, input logic [7:0] a, input logic [15:0] d);
        txn_t t;
        t.we    = we;
        t.addr  = a;
        t.wdata = d;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        logic [7:0] a;
        a = ($urandom_range(7) == 0) ? 8'hFF : 8'($urandom_range(15));
        return mk(1'($urandom_range(1)), a, 16'($urandom));
    endfunction

    // Advance the model across one clock edge, using the request lines the DUT just sampled.
    task automatic model_edge();
        bit w;
        case (tx_phase)
            0: begin
                if (m0_req || m1_req) begin
                    w         = (m0_req && m1_req) ? !mdl_last : m1_req;
                    mdl_last  = w;
                    mdl_owner = w;
                    mdl_we    = w ? m1_we    : m0_we;
                    mdl_addr  = w ? m1_addr  : m0_addr;
                    mdl_wdata = w ? m1_wdata : m0_wdata;
                    tx_phase  = 1;
                end
            end
            1: begin
                mdl_rdata[mdl_owner] = mem_model[mdl_addr];
                if (mdl_we) mem_model[mdl_addr] = mdl_wdata;
                tx_phase = 2;
            end
            default: tx_phase = 0;
        endcase
    endtask

    task automatic drive();
        m0_req   = act[0];
        m0_we    = cur[0].we;
        m0_addr  = cur[0].addr;
        m0_wdata = cur[0].wdata;
        m1_req   = act[1];
        m1_we    = cur[1].we;
        m1_addr  = cur[1].addr;
        m1_wdata = cur[1].wdata;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (ram_we) ram[ram_waddr] <= ram_wdata;
        @(negedge clk);
        model_edge();
        check("busy",      32'(busy),      32'(tx_phase != 0));
        check("ram_we",    32'(ram_we),    32'(tx_phase == 1 && mdl_we));
        check("ram_waddr", 32'(ram_waddr), 32'(mdl_addr));
        check("ram_raddr", 32'(ram_raddr), 32'(mdl_addr));
        check("ram_wdata", 32'(ram_wdata), 32'(mdl_wdata));
        check("m0_ack",    32'(m0_ack),    32'(tx_phase == 2 && !mdl_owner));
        check("m1_ack",    32'(m1_ack),    32'(tx_phase == 2 && mdl_owner));
        check("m0_rdata",  32'(m0_rdata),  32'(mdl_rdata[0]));
        check("m1_rdata",  32'(m1_rdata),  32'(mdl_rdata[1]));
        check("ack_overlap", 32'(m0_ack & m1_ack), 32'(0));
        if (ram_we) we_cnt++;
        if (m0_ack) begin
            act[0] = 1'b0; ack_log.push_back(0); ack_cnt[0]++; lat[0] = cyc - req_cyc[0] + 1;
        end
        if (m1_ack) begin
            act[1] = 1'b0; ack_log.push_back(1); ack_cnt[1]++; lat[1] = cyc - req_cyc[1] + 1;
        end
        if (!act[0] && q0.size() > 0) begin
            cur[0] = q0.pop_front(); act[0] = 1'b1; req_cyc[0] = cyc;
        end
        if (!act[1] && q1.size() > 0) begin
            cur[1] = q1.pop_front(); act[1] = 1'b1; req_cyc[1] = cyc;
        end
        drive();
        cyc++;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((act[0] || act[1] || q0.size() > 0 || q1.size() > 0 || tx_phase != 0) && n < 200) begin
            cycle();
            n++;
        end
        check({tag, "_drain_timeout"}, 32'(n < 200), 32'(1));
    endtask

    // Called just after a negedge; asserts reset, checks outputs cleared, releases on a later negedge.
    task automatic do_reset();
        rst_n = 1'b0;
        act[0] = 1'b0;
        act[1] = 1'b0;
        q0.delete();
        q1.delete();
        drive();
        #1;
        check("rst_ram_we",    32'(ram_we),    32'(0));
        check("rst_busy",      32'(busy),      32'(0));
        check("rst_m0_ack",    32'(m0_ack),    32'(0));
        check("rst_m1_ack",    32'(m1_ack),    32'(0));
        check("rst_ram_waddr", 32'(ram_waddr), 32'(0));
        check("rst_ram_raddr", 32'(ram_raddr), 32'(0));
        check("rst_ram_wdata", 32'(ram_wdata), 32'(0));
        check("rst_m0_rdata",  32'(m0_rdata),  32'(0));
        check("rst_m1_rdata",  32'(m1_rdata),  32'(0));
        tx_phase     = 0;
        mdl_last     = 1'b1;
        mdl_owner    = 1'b0;
        mdl_we       = 1'b0;
        mdl_addr     = '0;
        mdl_wdata    = '0;
        mdl_rdata[0] = '0;
        mdl_rdata[1] = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int a0, a1, w0;
        int exp2[4];
        int exp3[4];
        for (int i = 0; i < 256; i++) begin
            logic [15:0] v;
            v = 16'($urandom);
            ram[i]       = v;
            mem_model[i] = v;
        end
        cur[0] = mk(1'b0, 8'h00, 16'h0000);
        cur[1] = mk(1'b0, 8'h00, 16'h0000);
        act[0] = 1'b0;
        act[1] = 1'b0;
        ack_cnt[0] = 0;
        ack_cnt[1] = 0;
        mdl_rdata[0] = '0;
        mdl_rdata[1] = '0;
        @(negedge clk);
        do_reset();
        repeat (2) cycle();

        // 1: M0 write 0x12 <- 0xBEEF, then read it back.
        we_cnt = 0;
        q0.push_back(mk(1'b1, 8'h12, 16'hBEEF));
        drain("t1w");
        check("t1_write_latency", 32'(lat[0]), 32'(3));
        check("t1_we_cycles", 32'(we_cnt), 32'(1));
        q0.push_back(mk(1'b0, 8'h12, 16'h0000));
        drain("t1r");
        check("t1_read_latency", 32'(lat[0]), 32'(3));
        check("t1_rdata", 32'(m0_rdata), 32'(16'hBEEF));
        check("t1_we_after_read", 32'(we_cnt), 32'(1));

        // 2: both masters request together after reset, both keep re-requesting.
        do_reset();
        ack_log.delete();
        q0.push_back(mk(1'b0, 8'h01, 16'h0));
        q0.push_back(mk(1'b0, 8'h02, 16'h0));
        q1.push_back(mk(1'b0, 8'h03, 16'h0));
        q1.push_back(mk(1'b0, 8'h04, 16'h0));
        drain("t2");
        exp2 = '{0, 1, 0, 1};
        check("t2_grant_count", 32'(ack_log.size()), 32'(4));
        for (int i = 0; i < 4; i++)
            if (i < ack_log.size()) check($sformatf("t2_grant%0d", i), 32'(ack_log[i]), 32'(exp2[i]));

        // 3: M0 holds its request across three transactions; M1 arrives mid-transaction.
        ack_log.delete();
        q0.push_back(mk(1'b1, 8'h05, 16'h1111));
        q0.push_back(mk(1'b0, 8'h05, 16'h0));
        q0.push_back(mk(1'b1, 8'h06, 16'h2222));
        cycle();
        cycle();
        q1.push_back(mk(1'b0, 8'h05, 16'h0));
        drain("t3");
        exp3 = '{0, 1, 0, 0};
        check("t3_grant_count", 32'(ack_log.size()), 32'(4));
        for (int i = 0; i < 4; i++)
            if (i < ack_log.size()) check($sformatf("t3_grant%0d", i), 32'(ack_log[i]), 32'(exp3[i]));
        check("t3_m1_rdata", 32'(m1_rdata), 32'(16'h1111));

        // 4: M1 write/read at the top address, M0 idle.
        a0 = ack_cnt[0];
        q1.push_back(mk(1'b1, 8'hFF, 16'h0001));
        drain("t4w");
        q1.push_back(mk(1'b0, 8'hFF, 16'h0));
        drain("t4r");
        check("t4_rdata", 32'(m1_rdata), 32'(16'h0001));
        check("t4_m0_acks", 32'(ack_cnt[0]), 32'(a0));

        // 5: reset lands in the RAM cycle of a write; the write must not commit.
        q1.push_back(mk(1'b1, 8'h20, 16'h5555));
        drain("t5pre");
        q0.push_back(mk(1'b1, 8'h20, 16'hAAAA));
        cycle();
        cycle();
        check("t5_we_before_reset", 32'(ram_we), 32'(1));
        do_reset();
        q1.push_back(mk(1'b0, 8'h20, 16'h0));
        drain("t5r");
        check("t5_rdata_unchanged", 32'(m1_rdata), 32'(16'h5555));

        // Random traffic from both masters over a small address window plus the top address.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(2) == 0 && q0.size() < 2) q0.push_back(rand_txn());
            if ($urandom_range(2) == 0 && q1.size() < 2) q1.push_back(rand_txn());
            cycle();
        end
        drain("rnd");

        // 6: ten quiet cycles.
        a0 = ack_cnt[0];
        a1 = ack_cnt[1];
        w0 = we_cnt;
        repeat (10) cycle();
        check("t6_busy", 32'(busy), 32'(0));
        check("t6_m0_acks", 32'(ack_cnt[0]), 32'(a0));
        check("t6_m1_acks", 32'(ack_cnt[1]), 32'(a1));
        check("t6_we_cycles", 32'(we_cnt), 32'(w0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
